// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN pixel-streaming datapath:
// pixel format, legal feature-map widths and the streamer FSM states.
package cnn_pkg;

  localparam int BITSIZE   = 14;  // signed Q7.7 pixel
  localparam int FRAC_BITS = 7;
  localparam int MAX_W     = 112;
  localparam int ADDR_W    = 16;
  localparam int SIZE_W    = $clog2(MAX_W) + 1;
  localparam int CW        = $clog2(MAX_W + 2);

  localparam int W_LARGE = 112;
  localparam int W_MID   = 56;
  localparam int W_SMALL = 26;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } stream_state_e;

  function automatic logic is_legal_size(input int w);
    return (w == W_LARGE) || (w == W_MID) || (w == W_SMALL);
  endfunction

endpackage

// File: rtl/padded_pixel_streamer_if.sv
// Pixel stream to the 3x3 window generator plus the activation-SRAM read port.
// master = streamer side, slave = window generator / SRAM side.
interface padded_pixel_streamer_if #(
  parameter int BITSIZE = cnn_pkg::BITSIZE,
  parameter int ADDR_W  = cnn_pkg::ADDR_W,
  parameter int SIZE_W  = cnn_pkg::SIZE_W
);
  logic               mem_rd_en;
  logic [ADDR_W-1:0]  mem_rd_addr;
  logic [BITSIZE-1:0] mem_rd_data;
  logic [BITSIZE-1:0] input_pixel;
  logic               in_valid;
  logic               zero_buffer;
  logic               out_ready;
  logic               end_of_layer;
  logic [SIZE_W-1:0]  layer_fifosize;

  modport master (
    output mem_rd_en, mem_rd_addr, input_pixel, in_valid, zero_buffer,
           end_of_layer, layer_fifosize,
    input  mem_rd_data, out_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, input_pixel, in_valid, zero_buffer,
           end_of_layer, layer_fifosize,
    output mem_rd_data, out_ready
  );
endinterface

// File: rtl/pad_raster_counter.sv
// Raster walker over the zero-padded (W+2)x(W+2) grid: row/column counters,
// padding flag and the SRAM address of the next interior pixel.
module pad_raster_counter #(
  parameter int CW     = cnn_pkg::CW,
  parameter int ADDR_W = cnn_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic              step,
  input  logic [CW-1:0]     last_idx,
  output logic              is_pad,
  output logic              last_pos,
  output logic [ADDR_W-1:0] addr
);
  logic [CW-1:0] row, col;

  assign is_pad   = (row == '0) || (row == last_idx) || (col == '0) || (col == last_idx);
  assign last_pos = (row == last_idx) && (col == last_idx);

  // Interior pixels are visited in the same raster order they are stored, so
  // base + (r-1)*W + (c-1) is just a running count of interior issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (load) begin
      row  <= '0;
      col  <= '0;
      addr <= base;
    end else if (step) begin
      if (!is_pad) addr <= addr + ADDR_W'(1);
      if (col == last_idx) begin
        col <= '0;
        row <= last_pos ? '0 : row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/padded_pixel_streamer.sv
// Streams one zero-padded feature-map channel from SRAM to the window generator.
// Optional STREAMER_STALL_CNT_EN adds a saturating stall_cnt output.
module padded_pixel_streamer #(
  parameter int BITSIZE = cnn_pkg::BITSIZE,
  parameter int MAX_W   = cnn_pkg::MAX_W,
  parameter int ADDR_W  = cnn_pkg::ADDR_W,
  parameter int CW      = $clog2(MAX_W + 2)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [$clog2(MAX_W):0] layer_size,
  input  logic [ADDR_W-1:0]      base_addr,
  padded_pixel_streamer_if.master pix,
  output logic                   busy,
  output logic                   done,
  output logic                   size_err
`ifdef STREAMER_STALL_CNT_EN
  ,
  output logic [23:0]            stall_cnt
`endif
);
  import cnn_pkg::*;

  localparam int SW = $clog2(MAX_W) + 1;
  localparam logic [BITSIZE-1:0] ZERO_PIX = '0;

  stream_state_e     state, state_nx;
  logic [SW-1:0]     size_q;
  logic              in_valid_q, zero_q, eol_q, size_err_q;
  logic              out_vld, adv, accept, issue, legal;
  logic              is_pad, last_pos;
  logic [CW-1:0]     last_idx;
  logic [ADDR_W-1:0] rd_addr;

  assign legal    = is_legal_size(int'(layer_size));
  assign out_vld  = in_valid_q | zero_q;
  assign adv      = !out_vld || pix.out_ready;
  assign accept   = (state == IDLE) && start && legal;
  assign issue    = (state == STREAM) && adv;
  assign last_idx = CW'(size_q + SW'(1));

  pad_raster_counter #(.CW(CW), .ADDR_W(ADDR_W)) u_raster (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .base     (base_addr),
    .step     (issue),
    .last_idx (last_idx),
    .is_pad   (is_pad),
    .last_pos (last_pos),
    .addr     (rd_addr)
  );

  // NOTE: always_comb assigns every output a default first so no path leaves
  // state_nx unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = STREAM;
      STREAM:  if (issue && last_pos) state_nx = DRAIN;
      DRAIN:   if (pix.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Stage 1: flags hold while stalled; the SRAM keeps its data since no read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_valid_q <= 1'b0;
      zero_q     <= 1'b0;
      eol_q      <= 1'b0;
      size_err_q <= 1'b0;
      size_q     <= '0;
    end else begin
      if (adv) begin
        in_valid_q <= issue && !is_pad;
        zero_q     <= issue && is_pad;
      end
      eol_q      <= (state == DRAIN) && pix.out_ready;
      size_err_q <= (state == IDLE) && start && !legal;
      if (accept) size_q <= layer_size;
    end
  end

`ifdef STREAMER_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                              stall_cnt <= '0;
    else if (accept)                                      stall_cnt <= '0;
    else if (out_vld && !pix.out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 24'd1;
  end
`endif

  assign pix.mem_rd_en      = issue && !is_pad;
  assign pix.mem_rd_addr    = rd_addr;
  assign pix.input_pixel    = in_valid_q ? pix.mem_rd_data : ZERO_PIX;
  assign pix.in_valid       = in_valid_q;
  assign pix.zero_buffer    = zero_q;
  assign pix.end_of_layer   = eol_q;
  assign pix.layer_fifosize = size_q;
  assign busy               = (state != IDLE);
  assign done               = eol_q;
  assign size_err           = size_err_q;

endmodule

// File: tb/tb_padded_pixel_streamer.sv
// Randomized self-checking bench for padded_pixel_streamer against a
// grid-level reference model (expected stream built from r/c arithmetic).
module tb_padded_pixel_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  layer_size = '0;
  logic [15:0] base_addr = '0;
  logic        busy, done, size_err;
`ifdef STREAMER_STALL_CNT_EN
  logic [23:0] stall_cnt;
`endif

  padded_pixel_streamer_if mif ();

  padded_pixel_streamer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .layer_size (layer_size),
    .base_addr  (base_addr),
    .pix        (mif),
    .busy       (busy),
    .done       (done),
    .size_err   (size_err)
`ifdef STREAMER_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // SRAM model: one-cycle read latency, output held while not reading.
  logic [13:0] mem [0:65535];
  logic [13:0] rd_q = '0;
  always @(posedge clk) if (mif.mem_rd_en) rd_q <= mem[mif.mem_rd_addr];
  assign mif.mem_rd_data = rd_q;

  typedef struct packed {
    logic        pad;
    logic [13:0] px;
  } pos_t;

  pos_t        exp_q[$], obs_q[$];
  logic [15:0] exp_addr[$], obs_addr[$];

  int checks = 0;
  int errors = 0;
  int n_valid, n_zero, first_out, last_out, eol_cnt, eol_cyc, done_cnt;
  int stall_cyc, stall_rd, both, size_bad, serr_cnt;
  bit busy0, timeout;

  function automatic void build_model(input int w, input logic [15:0] base);
    logic [15:0] a;
    exp_q.delete();
    exp_addr.delete();
    for (int r = 0; r < w + 2; r++)
      for (int c = 0; c < w + 2; c++)
        if (r == 0 || r == w + 1 || c == 0 || c == w + 1) begin
          exp_q.push_back(pos_t'({1'b1, 14'd0}));
        end else begin
          a = 16'(int'(base) + (r - 1) * w + (c - 1));
          exp_addr.push_back(a);
          exp_q.push_back(pos_t'({1'b0, mem[a]}));
        end
  endfunction

  function automatic int seq_diff();
    int n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
    if (obs_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic int addr_diff();
    int n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) if (obs_addr[i] !== exp_addr[i]) return i;
    if (obs_addr.size() != exp_addr.size()) return n;
    return -1;
  endfunction

  task automatic sample(input int k, input int w);
    bit vld;
    vld = mif.in_valid | mif.zero_buffer;
    if (mif.in_valid && mif.zero_buffer) both++;
    if (mif.mem_rd_en) obs_addr.push_back(mif.mem_rd_addr);
    if (vld && !mif.out_ready) begin
      stall_cyc++;
      if (mif.mem_rd_en) stall_rd++;
    end
    if (vld && mif.out_ready) begin
      obs_q.push_back(pos_t'({mif.zero_buffer, mif.input_pixel}));
      if (mif.in_valid) n_valid++; else n_zero++;
      if (first_out < 0) first_out = k;
      last_out = k;
    end
    if (mif.end_of_layer) begin eol_cnt++; eol_cyc = k; end
    if (done) done_cnt++;
    if (size_err) serr_cnt++;
    if (int'(mif.layer_fifosize) != w) size_bad++;
    if (k == 0) busy0 = busy;
  endtask

  // mode 0: ready always, 1: 1-0-0-1 pattern, 2: random. poke: start mid-stream.
  task automatic run_layer(input int w, input logic [15:0] base, input int mode, input bit poke);
    int  k, budget;
    bit  got_done;
    build_model(w, base);
    obs_q.delete();
    obs_addr.delete();
    n_valid = 0; n_zero = 0; first_out = -1; last_out = -1; eol_cnt = 0; eol_cyc = -1;
    done_cnt = 0; stall_cyc = 0; stall_rd = 0; both = 0; size_bad = 0; serr_cnt = 0;
    busy0 = 0;
    budget = 4 * (w + 2) * (w + 2) + 100;
    @(posedge clk); #1;
    start = 1'b1; layer_size = 8'(w); base_addr = base;
    @(posedge clk); #1;
    start = 1'b0; layer_size = 8'($urandom_range(0, 255)); base_addr = 16'($urandom);
    k = 0;
    got_done = 0;
    while (!got_done && k < budget) begin
      case (mode)
        0:       mif.out_ready = 1'b1;
        1:       mif.out_ready = (k % 4 == 0) || (k % 4 == 3);
        default: mif.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (poke && k == 100) begin
        start = 1'b1; layer_size = 8'd26; base_addr = ~base;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      sample(k, w);
      if (done) got_done = 1;
      @(posedge clk); #1;
      k++;
    end
    timeout = !got_done;
    mif.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (mif.end_of_layer) eol_cnt++;
      if (done) done_cnt++;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({mif.in_valid, mif.zero_buffer, mif.mem_rd_en, mif.end_of_layer, busy, done, size_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000000",
               {mif.in_valid, mif.zero_buffer, mif.mem_rd_en, mif.end_of_layer, busy, done, size_err});
    end
    checks++;
    if (mif.layer_fifosize !== 8'd0) begin
      errors++; $display("FAIL reset_fifosize got %0d want 0", mif.layer_fifosize);
    end
    checks++;
    if (mif.input_pixel !== 14'd0 || mif.mem_rd_addr !== 16'd0) begin
      errors++; $display("FAIL reset_buses got pix=%h addr=%h want 0", mif.input_pixel, mif.mem_rd_addr);
    end
    #10 rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_size26();
    int pads;
    run_layer(26, 16'h0100, 0, 0);
    checks++;
    if (timeout) begin errors++; $display("FAIL s26_timeout got no done want done"); end
    checks++;
    if (obs_q.size() != 784) begin errors++; $display("FAIL s26_outputs got %0d want 784", obs_q.size()); end
    checks++;
    if (n_valid != 676 || n_zero != 108) begin
      errors++; $display("FAIL s26_split got valid=%0d zero=%0d want 676/108", n_valid, n_zero);
    end
    checks++;
    if (last_out - first_out + 1 != 784) begin
      errors++; $display("FAIL s26_consecutive got span %0d want 784", last_out - first_out + 1);
    end
    checks++;
    if (first_out != 1 || busy0 !== 1'b1) begin
      errors++; $display("FAIL s26_latency got first=%0d busy0=%0d want 1/1", first_out, busy0);
    end
    pads = 0;
    for (int i = 0; i < 29 && i < obs_q.size(); i++) if (obs_q[i].pad) pads++;
    checks++;
    if (pads != 29) begin errors++; $display("FAIL s26_first_pads got %0d want 29", pads); end
    checks++;
    if (obs_addr.size() != 676 || obs_addr[0] !== 16'h0100 || obs_addr[obs_addr.size()-1] !== 16'h0100 + 16'd675) begin
      errors++;
      $display("FAIL s26_addr_ends got n=%0d first=%h last=%h want 676/0100/03a3",
               obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : 16'hxxxx,
               (obs_addr.size() > 0) ? obs_addr[obs_addr.size()-1] : 16'hxxxx);
    end
    checks++;
    if (eol_cnt != 1 || done_cnt != 1 || eol_cyc != last_out + 1) begin
      errors++; $display("FAIL s26_eol got eol=%0d done=%0d at %0d want 1/1 at %0d",
                         eol_cnt, done_cnt, eol_cyc, last_out + 1);
    end
    checks++;
    if (seq_diff() != -1) begin errors++; $display("FAIL s26_sequence got diff at %0d want none", seq_diff()); end
    checks++;
    if (both != 0 || serr_cnt != 0 || size_bad != 0) begin
      errors++; $display("FAIL s26_flags got both=%0d serr=%0d sizebad=%0d want 0", both, serr_cnt, size_bad);
    end
  endtask

  task automatic test_stall();
    logic [15:0] base = 16'($urandom);
    run_layer(56, base, 1, 0);
    checks++;
    if (timeout || seq_diff() != -1) begin
      errors++; $display("FAIL stall56_sequence got diff at %0d timeout=%0d want none", seq_diff(), timeout);
    end
    checks++;
    if (stall_rd != 0 || stall_cyc == 0) begin
      errors++; $display("FAIL stall56_reads got stalled_reads=%0d stalls=%0d want 0/>0", stall_rd, stall_cyc);
    end
    checks++;
    if (addr_diff() != -1) begin errors++; $display("FAIL stall56_addrs got diff at %0d want none", addr_diff()); end
    checks++;
    if (eol_cnt != 1 || done_cnt != 1) begin
      errors++; $display("FAIL stall56_eol got eol=%0d done=%0d want 1/1", eol_cnt, done_cnt);
    end
`ifdef STREAMER_STALL_CNT_EN
    checks++;
    if (int'(stall_cnt) != stall_cyc) begin
      errors++; $display("FAIL stall56_cnt got %0d want %0d", stall_cnt, stall_cyc);
    end
`endif
    base = 16'($urandom);
    run_layer(26, base, 2, 0);
    checks++;
    if (timeout || seq_diff() != -1 || stall_rd != 0) begin
      errors++; $display("FAIL stall_rand_sequence got diff at %0d stalled_reads=%0d want none/0", seq_diff(), stall_rd);
    end
`ifdef STREAMER_STALL_CNT_EN
    checks++;
    if (int'(stall_cnt) != stall_cyc) begin
      errors++; $display("FAIL stall_rand_cnt got %0d want %0d", stall_cnt, stall_cyc);
    end
`endif
  endtask

  task automatic test_size112();
    logic [15:0] base = 16'($urandom);
    run_layer(112, base, 0, 0);
    checks++;
    if (timeout || seq_diff() != -1) begin
      errors++; $display("FAIL s112_sequence got diff at %0d want none", seq_diff());
    end
    checks++;
    if (size_bad != 0) begin errors++; $display("FAIL s112_fifosize got %0d bad cycles want 0", size_bad); end
    checks++;
    if (obs_addr.size() < 113 || obs_addr[112] !== base + 16'd112) begin
      errors++; $display("FAIL s112_row2_addr got %h want %h",
                         (obs_addr.size() > 112) ? obs_addr[112] : 16'hxxxx, base + 16'd112);
    end
    checks++;
    if (obs_q.size() < 229 || obs_q[114 + 112].pad !== 1'b0 || obs_q[114 + 113].pad !== 1'b1 || obs_q[228].pad !== 1'b1) begin
      errors++; $display("FAIL s112_row_edge got pads c112/c113/c0 wrong want 0/1/1");
    end
  endtask

  task automatic test_start_ignored();
    logic [15:0] base = 16'($urandom);
    run_layer(56, base, 2, 1);
    checks++;
    if (timeout || seq_diff() != -1 || addr_diff() != -1) begin
      errors++; $display("FAIL poke_sequence got diff %0d/%0d want none", seq_diff(), addr_diff());
    end
    checks++;
    if (size_bad != 0 || eol_cnt != 1) begin
      errors++; $display("FAIL poke_latched got sizebad=%0d eol=%0d want 0/1", size_bad, eol_cnt);
    end
  endtask

  task automatic test_bad_size();
    int bad = 0;
    @(posedge clk); #1;
    start = 1'b1; layer_size = 8'd40; base_addr = 16'h1234;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (size_err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL bad_size_pulse got err=%0d busy=%0d want 1/0", size_err, busy);
    end
    repeat (6) begin
      @(negedge clk);
      if (size_err || busy || mif.mem_rd_en || mif.in_valid || mif.zero_buffer) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bad_size_quiet got %0d active cycles want 0", bad); end
    run_layer(26, 16'($urandom), 0, 0);
    checks++;
    if (timeout || seq_diff() != -1 || eol_cnt != 1) begin
      errors++; $display("FAIL bad_size_recover got diff %0d eol=%0d want none/1", seq_diff(), eol_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0, k = 0, bad = 0;
    mif.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; layer_size = 8'd26; base_addr = 16'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    while (n < 300 && k < 2000) begin
      @(negedge clk);
      if (mif.in_valid | mif.zero_buffer) n++;
      k++;
    end
    checks++;
    if (n != 300) begin errors++; $display("FAIL rst_mid_reach got %0d outputs want 300", n); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mif.in_valid, mif.zero_buffer, mif.mem_rd_en, mif.end_of_layer, busy, done} !== 6'b0 ||
        mif.input_pixel !== 14'd0 || mif.layer_fifosize !== 8'd0) begin
      errors++; $display("FAIL rst_mid_async got flags=%b pix=%h size=%0d want 0",
                         {mif.in_valid, mif.zero_buffer, mif.mem_rd_en, mif.end_of_layer, busy, done},
                         mif.input_pixel, mif.layer_fifosize);
    end
    repeat (3) begin
      @(negedge clk);
      if (mif.end_of_layer || done || busy) bad++;
    end
    #1 rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (mif.end_of_layer || done || busy) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_mid_no_eol got %0d events want 0", bad); end
    run_layer(26, 16'($urandom), 2, 0);
    checks++;
    if (timeout || seq_diff() != -1 || obs_q.size() != 784 || eol_cnt != 1) begin
      errors++; $display("FAIL rst_mid_restart got n=%0d diff=%0d eol=%0d want 784/none/1",
                         obs_q.size(), seq_diff(), eol_cnt);
    end
  endtask

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog got no completion want summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mif.out_ready = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 14'($urandom);
    test_reset();
    test_size26();
    test_stall();
    test_size112();
    test_start_ignored();
    test_bad_size();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
